if_stage_unit: RTL

- Instruction-fetch stage of the 5-stage LoongArch pipeline, directly upstream of the decode stage.
- Generates the next PC, either sequential or from the branch redirect. Drives a synchronous instruction SRAM with 1-cycle read latency.
- Holds the fetched word when decode back-pressures, and squashes wrong-path fetches on a taken branch.
- Presents {pc, inst} with a valid/allow-in handshake.

---
 rtl/if_stage_unit.sv | 128 ++++++++++++
 1 files changed

// File: rtl/if_stage_unit.sv
// Instruction-fetch stage: next-PC generation, 1-cycle-latency instruction
// SRAM request, stall buffer for the returned word and wrong-path squash on
// a taken branch. {pc, inst} is offered to decode with a valid/allow-in
// handshake.
// Optional feature macro: IF_ADEF_CHECK_EN (misaligned-fetch detection).
module if_stage_unit #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ID_Allow_in,
  input  logic [33:0] br_bus,
  output logic        IF_to_ID_Valid,
  output logic [63:0] IF_to_ID_Bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  output logic        if_adef
);

  localparam logic [31:0] NOP_INST = 32'h03400000;

  logic        br_taken;
  logic [31:0] br_target;
  logic        unused_stall;

  logic [31:0] pc;
  logic        if_valid;
  logic        buf_valid;
  logic [31:0] inst_buf;

  logic [31:0] seq_pc;
  logic [31:0] nextpc;
  logic        if_ready_go;
  logic        if_allow_in;
  logic        fetch_go;
  logic        buf_load;
  logic [31:0] inst;

  assign br_taken     = br_bus[33];
  assign br_target    = br_bus[32:1];
  assign unused_stall = br_bus[0];

  assign if_ready_go  = 1'b1;

  // Next-PC selection and stage-advance decision
  always_comb begin
    seq_pc      = pc + 32'd4;
    nextpc      = br_taken ? br_target : seq_pc;
    if_allow_in = ~if_valid | (if_ready_go & ID_Allow_in) | br_taken;
    fetch_go    = ~reset & if_allow_in;
    buf_load    = if_valid & ~ID_Allow_in & ~buf_valid & ~br_taken;
  end

  // PC, valid and buffer-valid state
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC - 32'd4;
      if_valid  <= 1'b0;
      buf_valid <= 1'b0;
    end else if (fetch_go) begin
      pc        <= nextpc;
      if_valid  <= 1'b1;
      buf_valid <= 1'b0;
    end else if (buf_load) begin
      buf_valid <= 1'b1;
    end
  end

  // Capture the SRAM word in its only valid cycle when decode stalls
  always_ff @(posedge clk) begin
    if (!reset && !fetch_go && buf_load) begin
      inst_buf <= inst_sram_rdata;
    end
  end

`ifdef IF_ADEF_CHECK_EN
  logic adef_q;
  logic misaligned;

  assign misaligned = |nextpc[1:0];

  // Remember whether the instruction now in IF came from a misaligned fetch
  always_ff @(posedge clk) begin
    if (reset) begin
      adef_q <= 1'b0;
    end else if (fetch_go) begin
      adef_q <= misaligned;
    end
  end

  // Misaligned fetches advance the stage but never reach the SRAM
  always_comb begin
    inst_sram_en = fetch_go & ~misaligned;
    if (adef_q) begin
      inst = NOP_INST;
    end else if (buf_valid) begin
      inst = inst_buf;
    end else begin
      inst = inst_sram_rdata;
    end
    if_adef = adef_q & IF_to_ID_Valid;
  end
`else
  logic [31:0] unused_nop;

  assign unused_nop = NOP_INST;

  // Plain fetch path: every advance is an SRAM request
  always_comb begin
    inst_sram_en = fetch_go;
    inst         = buf_valid ? inst_buf : inst_sram_rdata;
    if_adef      = 1'b0;
  end
`endif

  // Decode-side handshake outputs and constant SRAM write side
  always_comb begin
    IF_to_ID_Valid  = if_valid & if_ready_go & ~br_taken;
    IF_to_ID_Bus    = {pc, inst};
    inst_sram_addr  = nextpc;
    inst_sram_we    = '0;
    inst_sram_wdata = '0;
  end

endmodule
